// File: rtl/eth_frame_tx.sv
// RMII Ethernet frame transmitter: preamble/SFD, prefetched RAM payload, zero pad, optional FCS, IFG.
// Define ETH_TX_FCS_EN to build the CRC-32 generator and append the 4-byte FCS.
module eth_frame_tx #(
    parameter int unsigned RAM_SIZE     = 2048,
    parameter int unsigned MIN_PAYLOAD  = 60,
    parameter int unsigned MAX_PAYLOAD  = 1514,
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned IFG_BYTES    = 12,
    localparam int unsigned AW          = $clog2(RAM_SIZE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] data_start,
    input  logic [AW-1:0] data_end,
    output logic          ram_read_req,
    output logic [AW-1:0] ram_read_addr,
    input  logic          ram_read_ready,
    input  logic [7:0]    ram_read_out,
    output logic          eth_txen,
    output logic [1:0]    eth_txd,
    output logic          busy,
    output logic          done,
    output logic          underrun
);

    localparam int unsigned CW      = 16;
    localparam int unsigned IFG_CYC = 4 * IFG_BYTES;
`ifdef ETH_TX_FCS_EN
    localparam bit FCS_EN = 1'b1;
`else
    localparam bit FCS_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_SFD, S_PAYLOAD, S_PAD, S_FCS, S_IFG
    } state_e;

    // First state at or after s that actually has bytes to send.
    function automatic state_e skip_empty(input state_e s, input logic [CW-1:0] len,
                                          input logic [CW-1:0] pad);
        state_e r;
        r = s;
        if (r == S_PREAMBLE && PREAMBLE_LEN == 0) r = S_SFD;
        if (r == S_PAYLOAD && len == '0)          r = S_PAD;
        if (r == S_PAD && pad == '0)              r = S_FCS;
        if (r == S_FCS && !FCS_EN)                r = S_IFG;
        return r;
    endfunction

    state_e        r_state, w_state_nxt, w_cand;
    logic [CW-1:0] r_cnt, w_cnt_nxt, w_cand_cnt, w_cnt_inc;
    logic [CW-1:0] r_len, w_len_nxt, r_pad, w_pad_nxt, w_len_eff;
    logic [CW-1:0] w_len_raw, w_len_c, w_pad_c;
    logic [1:0]    r_phase, w_phase_nxt;
    logic [7:0]    r_byte, w_byte_nxt, r_buf;
    logic          r_buf_vld;
    logic [AW-1:0] r_ptr, w_ptr_nxt, w_ptr_eff, r_addr, w_addr_nxt;
    logic          w_accept, w_enter, w_consume, w_fetch, w_underrun_nxt;
    logic          r_txen, w_txen_nxt, r_busy, w_busy_nxt, r_done, w_done_nxt, r_underrun, r_req;
    logic [1:0]    r_txd, w_txd_nxt;

    // Frame length sampled on start: wrapped distance, clamped, then padding needed.
    assign w_len_raw = (data_end >= data_start) ? CW'(data_end) - CW'(data_start)
                                                : CW'(RAM_SIZE) - CW'(data_start) + CW'(data_end);
    assign w_len_c   = (w_len_raw > CW'(MAX_PAYLOAD)) ? CW'(MAX_PAYLOAD) : w_len_raw;
    assign w_pad_c   = (w_len_c < CW'(MIN_PAYLOAD)) ? CW'(MIN_PAYLOAD) - w_len_c : '0;
    assign w_cnt_inc = r_cnt + CW'(1);

`ifdef ETH_TX_FCS_EN
    logic [31:0] r_crc, w_crc_upd;

    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // CRC folds in the dibit currently on the wire while in payload or pad.
    assign w_crc_upd = (r_state == S_PAYLOAD || r_state == S_PAD) ? crc_dibit(r_crc, r_txd) : r_crc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        r_crc <= '1;
        else if (w_accept) r_crc <= '1;
        else               r_crc <= w_crc_upd;
    end
`endif

    // State register, prefetch buffer and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_phase    <= '0;
            r_byte     <= '0;
            r_len      <= '0;
            r_pad      <= '0;
            r_ptr      <= '0;
            r_addr     <= '0;
            r_buf      <= '0;
            r_buf_vld  <= 1'b0;
            r_txen     <= 1'b0;
            r_txd      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
            r_req      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_phase    <= w_phase_nxt;
            r_byte     <= w_byte_nxt;
            r_len      <= w_len_nxt;
            r_pad      <= w_pad_nxt;
            r_ptr      <= w_ptr_nxt;
            r_addr     <= w_addr_nxt;
            r_txen     <= w_txen_nxt;
            r_txd      <= w_txd_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_underrun <= w_underrun_nxt;
            r_req      <= w_fetch;
            if (w_accept || w_consume) begin
                r_buf_vld <= 1'b0;
            end else if (ram_read_ready) begin
                r_buf     <= ram_read_out;
                r_buf_vld <= 1'b1;
            end
        end
    end

    // Next state: advance on the last dibit of each byte slot, then load the next slot.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_phase_nxt    = r_phase + 2'd1;
        w_byte_nxt     = r_byte;
        w_len_nxt      = r_len;
        w_pad_nxt      = r_pad;
        w_ptr_nxt      = r_ptr;
        w_addr_nxt     = r_addr;
        w_accept       = 1'b0;
        w_enter        = 1'b0;
        w_consume      = 1'b0;
        w_fetch        = 1'b0;
        w_underrun_nxt = 1'b0;
        w_cand         = r_state;
        w_cand_cnt     = '0;
        w_ptr_eff      = r_ptr;
        w_len_eff      = r_len;
        case (r_state)
            S_IDLE: begin
                w_phase_nxt = '0;
                if (start) begin
                    w_accept  = 1'b1;
                    w_enter   = 1'b1;
                    w_len_nxt = w_len_c;
                    w_pad_nxt = w_pad_c;
                    w_len_eff = w_len_c;
                    w_ptr_eff = data_start;
                    w_ptr_nxt = data_start;
                    w_cand    = skip_empty(S_PREAMBLE, w_len_c, w_pad_c);
                end
            end
            S_IFG: begin
                w_phase_nxt = '0;
                if (r_cnt == CW'(IFG_CYC - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                if (r_phase == 2'd3) begin
                    w_enter = 1'b1;
                    case (r_state)
                        S_PREAMBLE: if (w_cnt_inc < CW'(PREAMBLE_LEN)) begin
                                        w_cand = S_PREAMBLE; w_cand_cnt = w_cnt_inc;
                                    end else w_cand = S_SFD;
                        S_SFD:      w_cand = skip_empty(S_PAYLOAD, r_len, r_pad);
                        S_PAYLOAD:  if (w_cnt_inc < r_len) begin
                                        w_cand = S_PAYLOAD; w_cand_cnt = w_cnt_inc;
                                    end else w_cand = skip_empty(S_PAD, r_len, r_pad);
                        S_PAD:      if (w_cnt_inc < r_pad) begin
                                        w_cand = S_PAD; w_cand_cnt = w_cnt_inc;
                                    end else w_cand = skip_empty(S_FCS, r_len, r_pad);
                        S_FCS:      if (w_cnt_inc < CW'(4)) begin
                                        w_cand = S_FCS; w_cand_cnt = w_cnt_inc;
                                    end else w_cand = S_IFG;
                        default:    w_cand = S_IFG;
                    endcase
                end
            end
        endcase

        if (w_enter) begin
            w_state_nxt = w_cand;
            w_cnt_nxt   = w_cand_cnt;
            w_phase_nxt = '0;
            case (w_cand)
                S_PREAMBLE: w_byte_nxt = 8'h55;
                S_SFD:      w_byte_nxt = 8'hD5;
                S_PAYLOAD: begin
                    // Payload byte must already be buffered or arriving now, else abort.
                    if (r_buf_vld) begin
                        w_byte_nxt = r_buf;
                        w_consume  = 1'b1;
                    end else if (ram_read_ready) begin
                        w_byte_nxt = ram_read_out;
                        w_consume  = 1'b1;
                    end else begin
                        w_state_nxt    = S_IFG;
                        w_cnt_nxt      = '0;
                        w_underrun_nxt = 1'b1;
                    end
                end
`ifdef ETH_TX_FCS_EN
                S_FCS: begin
                    case (w_cand_cnt[1:0])
                        2'd0:    w_byte_nxt = ~w_crc_upd[7:0];
                        2'd1:    w_byte_nxt = ~w_crc_upd[15:8];
                        2'd2:    w_byte_nxt = ~w_crc_upd[23:16];
                        default: w_byte_nxt = ~w_crc_upd[31:24];
                    endcase
                end
`endif
                default:    w_byte_nxt = 8'h00;
            endcase
            if ((w_state_nxt == S_SFD && w_len_eff != '0) ||
                (w_state_nxt == S_PAYLOAD && (w_cand_cnt + CW'(1)) < w_len_eff)) begin
                w_fetch    = 1'b1;
                w_addr_nxt = w_ptr_eff;
                w_ptr_nxt  = (w_ptr_eff == AW'(RAM_SIZE - 1)) ? '0 : w_ptr_eff + AW'(1);
            end
        end
    end

    // Output decode from the next state, registered alongside it.
    always_comb begin
        w_txen_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_IFG);
        w_txd_nxt  = w_txen_nxt ? w_byte_nxt[{w_phase_nxt, 1'b0} +: 2] : 2'b00;
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (w_state_nxt == S_IFG) && (w_cnt_nxt == CW'(IFG_CYC - 1));
    end

    assign ram_read_req  = r_req;
    assign ram_read_addr = r_addr;
    assign eth_txen      = r_txen;
    assign eth_txd       = r_txd;
    assign busy          = r_busy;
    assign done          = r_done;
    assign underrun      = r_underrun;

endmodule

// File: tb/tb_eth_frame_tx.sv
// Directed bench for eth_frame_tx: RAM latency model, wire byte scoreboard, frame timing checks.
module tb_eth_frame_tx;

`ifdef ETH_TX_FCS_EN
    localparam int FCSB = 4;
`else
    localparam int FCSB = 0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic [10:0] data_start, data_end;
    logic        ram_read_req;
    logic [10:0] ram_read_addr;
    logic        ram_read_ready;
    logic [7:0]  ram_read_out;
    logic        eth_txen;
    logic [1:0]  eth_txd;
    logic        busy, done, underrun;

    eth_frame_tx dut (
        .clk(clk), .reset(reset), .start(start),
        .data_start(data_start), .data_end(data_end),
        .ram_read_req(ram_read_req), .ram_read_addr(ram_read_addr),
        .ram_read_ready(ram_read_ready), .ram_read_out(ram_read_out),
        .eth_txen(eth_txen), .eth_txd(eth_txd),
        .busy(busy), .done(done), .underrun(underrun)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  mem [0:2047];
    logic [7:0]  exp_q[$];
    int          pend_due[$];
    logic [7:0]  pend_dat[$];
    int          addr_q[$];
    int          lat = 2;
    int          cyc = 0;
    int          n_req = 0;
    int          ur_cnt = 0;
    int          txen_run = 0;

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) c = (c >> 1) ^ 32'hEDB88320;
            else             c = c >> 1;
        end
        return c;
    endfunction

    // RAM model: answers each request after 'lat' cycles.
    initial begin
        ram_read_ready = 1'b0;
        ram_read_out   = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            ram_read_ready = 1'b0;
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                ram_read_ready = 1'b1;
                ram_read_out   = pend_dat.pop_front();
                void'(pend_due.pop_front());
            end
            if (ram_read_req === 1'b1) begin
                pend_due.push_back(cyc + lat);
                pend_dat.push_back(mem[ram_read_addr]);
                addr_q.push_back(int'(ram_read_addr));
                n_req++;
            end
        end
    end

    // Wire monitor: reassembles LSB-first dibits into bytes and checks against the scoreboard.
    initial begin
        logic [7:0] sh;
        int         nd;
        logic       prev;
        sh = '0; nd = 0; prev = 1'b0;
        forever begin
            @(negedge clk);
            if (underrun === 1'b1) ur_cnt++;
            if (eth_txen === 1'b1) begin
                if (!prev) begin txen_run = 0; nd = 0; end
                txen_run++;
                sh = {eth_txd, sh[7:2]};
                nd++;
                if (nd == 4) begin
                    nd = 0;
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $error("FAIL wire_byte: observed=%0h expected=none", sh);
                    end else begin
                        check("wire_byte", {24'h0, sh}, {24'h0, exp_q.pop_front()});
                    end
                end
            end else begin
                check("txd_idle", {30'h0, eth_txd}, 32'h0);
            end
            prev = eth_txen;
        end
    end

    // Scoreboard push: preamble, SFD, then (if full) payload, pad and FCS; returns start-to-done cycles.
    task automatic push_frame(input int s, input int e, input bit full, output int cycles);
        int          n, pad;
        logic [31:0] crc;
        logic [7:0]  b;
        n = (e - s + 2048) % 2048;
        if (n > 1514) n = 1514;
        pad = (n < 60) ? 60 - n : 0;
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        crc = 32'hFFFFFFFF;
        if (full) begin
            for (int i = 0; i < n; i++) begin
                b = mem[(s + i) % 2048];
                exp_q.push_back(b);
                crc = crc_byte(crc, b);
            end
            for (int i = 0; i < pad; i++) begin
                exp_q.push_back(8'h00);
                crc = crc_byte(crc, 8'h00);
            end
`ifdef ETH_TX_FCS_EN
            crc = ~crc;
            exp_q.push_back(crc[7:0]);
            exp_q.push_back(crc[15:8]);
            exp_q.push_back(crc[23:16]);
            exp_q.push_back(crc[31:24]);
`endif
        end
        cycles = 4 * (8 + n + pad + FCSB) + 48;
    endtask

    task automatic kick(input int s, input int e);
        @(posedge clk); #1;
        data_start = 11'(s);
        data_end   = 11'(e);
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("txen_rise", {31'h0, eth_txen}, 32'h1);
        check("busy_rise", {31'h0, busy}, 32'h1);
        check("txd_first", {30'h0, eth_txd}, 32'h1);
    endtask

    task automatic wait_done(output int c, output bit ok);
        c = 0; ok = 1'b0;
        for (int k = 0; k < 10000; k++) begin
            @(negedge clk);
            c++;
            if (done === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic finish_frame(input int exp_cyc);
        int c;
        bit ok;
        wait_done(c, ok);
        check("done_seen", {31'h0, ok}, 32'h1);
        check("frame_cycles", c, exp_cyc);
        check("txen_len", txen_run, exp_cyc - 48);
        @(posedge clk); #1;
        check("busy_low", {31'h0, busy}, 32'h0);
        check("done_low", {31'h0, done}, 32'h0);
        check("queue_drained", exp_q.size(), 32'h0);
    endtask

    initial begin
        int c, c2;
        bit ok;
        int r0;
        reset = 1'b0; start = 1'b0; data_start = '0; data_end = '0;
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 9; i++) mem[i] = 8'(8'h31 + i);
        mem[2046] = 8'hA1;
        mem[2047] = 8'hB2;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_txen", {31'h0, eth_txen}, 32'h0);
        check("rst_txd", {30'h0, eth_txd}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_underrun", {31'h0, underrun}, 32'h0);
        check("rst_req", {31'h0, ram_read_req}, 32'h0);
        reset = 1'b1;

        // "123456789" frame, 1-cycle RAM
        lat = 1;
        push_frame(0, 9, 1'b1, c);
        kick(0, 9);
        finish_frame(c);

        // Empty payload: all pad, no reads
        lat = 2;
        r0 = n_req;
        push_frame(100, 100, 1'b1, c);
        kick(100, 100);
        finish_frame(c);
        check("no_reads_empty", n_req - r0, 32'h0);

        // Address wrap with the slowest legal RAM
        lat = 3;
        addr_q.delete();
        push_frame(2046, 2, 1'b1, c);
        kick(2046, 2);
        finish_frame(c);
        check("wrap_nreads", addr_q.size(), 32'd4);
        if (addr_q.size() == 4) begin
            check("wrap_addr0", addr_q[0], 32'd2046);
            check("wrap_addr1", addr_q[1], 32'd2047);
            check("wrap_addr2", addr_q[2], 32'd0);
            check("wrap_addr3", addr_q[3], 32'd1);
        end

        // Underrun with a 5-cycle RAM
        lat = 5;
        ur_cnt = 0;
        push_frame(0, 9, 1'b0, c);
        kick(0, 9);
        wait_done(c, ok);
        check("ur_done_seen", {31'h0, ok}, 32'h1);
        check("ur_pulses", ur_cnt, 32'h1);
        check("ur_txen_short", {31'h0, (txen_run >= 32 && txen_run <= 36)}, 32'h1);
        check("ur_ifg", c, txen_run + 48);
        @(posedge clk); #1;
        check("ur_busy_low", {31'h0, busy}, 32'h0);
        check("ur_queue", exp_q.size(), 32'h0);
        lat = 2;
        repeat (10) @(posedge clk);

        // Starts during busy and on the done cycle are ignored; one cycle later is accepted
        push_frame(20, 30, 1'b1, c);
        kick(20, 30);
        repeat (50) @(posedge clk);
        #1;
        data_start = 11'd500; data_end = 11'd600; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_hold", {31'h0, busy}, 32'h1);
        wait_done(c2, ok);
        check("f5_done_seen", {31'h0, ok}, 32'h1);
        check("f5_txen_len", txen_run, c - 48);
        data_start = 11'd0; data_end = 11'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("done_start_busy", {31'h0, busy}, 32'h0);
        check("done_start_txen", {31'h0, eth_txen}, 32'h0);
        push_frame(0, 9, 1'b1, c);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("restart_txen", {31'h0, eth_txen}, 32'h1);
        check("restart_busy", {31'h0, busy}, 32'h1);
        finish_frame(c);

        // Reset mid-payload, then a clean frame
        push_frame(0, 9, 1'b1, c);
        kick(0, 9);
        repeat (40) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_txen", {31'h0, eth_txen}, 32'h0);
        check("mid_rst_txd", {30'h0, eth_txd}, 32'h0);
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        exp_q.delete();
        pend_due.delete();
        pend_dat.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        push_frame(3, 40, 1'b1, c);
        kick(3, 40);
        finish_frame(c);

        // Oversize payload truncated
        r0 = n_req;
        push_frame(0, 2000, 1'b1, c);
        kick(0, 2000);
        finish_frame(c);
        check("max_reads", n_req - r0, 32'd1514);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
